// File: rtl/spi_sub_rx.sv
// SPI subordinate receiver: synchronises sclk/mosi/csb into sys_clk, shifts WORD_WIDTH+2 bit frames.
// Optional saturating frame-error counter on err_count when SPI_SUB_RX_ERR_CNT_EN is defined.
module spi_sub_rx #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  csb,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic [1:0]            power_state_out,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
`ifdef SPI_SUB_RX_ERR_CNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  localparam int FRAME_W = WORD_WIDTH + 2;
  localparam int CNT_MAX = WORD_WIDTH + 3;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ARMED} state_t;

  // Stops at CNT_MAX so an overlong frame can never wrap back to a legal length.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_W'(CNT_MAX)) return c;
    return c + CNT_W'(1);
  endfunction

  logic sclk_s1, sclk_s2, csb_s1, csb_s2, mosi_s1, mosi_s2;
  logic sclk_d, csb_d;
  logic sclk_fall_p0, csb_fall_p0, csb_rise_p0, mosi_p0;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load, err;

  // Stage: two-flop synchronisers, then registered edge pulses (_p0)
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sclk_s1      <= 1'b0;
      sclk_s2      <= 1'b0;
      csb_s1       <= 1'b0;
      csb_s2       <= 1'b0;
      mosi_s1      <= 1'b0;
      mosi_s2      <= 1'b0;
      sclk_d       <= 1'b0;
      csb_d        <= 1'b0;
      sclk_fall_p0 <= 1'b0;
      csb_fall_p0  <= 1'b0;
      csb_rise_p0  <= 1'b0;
      mosi_p0      <= 1'b0;
    end else begin
      sclk_s1      <= sclk;
      sclk_s2      <= sclk_s1;
      csb_s1       <= csb;
      csb_s2       <= csb_s1;
      mosi_s1      <= mosi;
      mosi_s2      <= mosi_s1;
      sclk_d       <= sclk_s2;
      csb_d        <= csb_s2;
      sclk_fall_p0 <= sclk_d & ~sclk_s2;
      csb_fall_p0  <= csb_d & ~csb_s2;
      csb_rise_p0  <= ~csb_d & csb_s2;
      mosi_p0      <= mosi_s2;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= ARMED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      ARMED: begin
        // csb_d is the synchronised csb level aligned with the _p0 pulses
        if (csb_d) state_d = IDLE;
      end
      IDLE: begin
        if (csb_fall_p0) begin
          state_d = ACTIVE;
          shift_d = '0;
          cnt_d   = '0;
          if (sclk_fall_p0) begin
            shift_d = FRAME_W'(mosi_p0);
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ACTIVE: begin
        if (csb_rise_p0) begin
          state_d = IDLE;
          if (cnt_q == CNT_W'(FRAME_W)) load = 1'b1;
          else                          err  = 1'b1;
        end else if (sclk_fall_p0) begin
          shift_d = {shift_q[FRAME_W-2:0], mosi_p0};
          cnt_d   = sat_inc(cnt_q);
        end
      end
      default: state_d = ARMED;
    endcase
  end

  // Stage: frame datapath and registered outputs
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      shift_q         <= '0;
      cnt_q           <= '0;
      data_out        <= '0;
      power_state_out <= 2'b00;
      valid           <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      valid     <= load;
      frame_err <= err;
      if (load) begin
        data_out        <= shift_q[WORD_WIDTH-1:0];
        power_state_out <= shift_q[FRAME_W-1:WORD_WIDTH];
      end
    end
  end

  assign busy = (state_q == ACTIVE);

`ifdef SPI_SUB_RX_ERR_CNT_EN
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                               err_count <= 8'd0;
    else if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_spi_sub_rx.sv
// Bench for spi_sub_rx: directed and random SPI frames checked each cycle against a frame-level model.
// Builds with or without SPI_SUB_RX_ERR_CNT_EN.
`timescale 1ns/1ps
module tb_spi_sub_rx;
  localparam int WW = 16;

  logic sys_clk = 1'b0;
  logic rst = 1'b1, sclk = 1'b1, mosi = 1'b0, csb = 1'b1;
  logic [WW-1:0] data_out;
  logic [1:0]    power_state_out;
  logic          valid, frame_err, busy;
`ifdef SPI_SUB_RX_ERR_CNT_EN
  logic [7:0]    err_count;
`endif

  spi_sub_rx #(.WORD_WIDTH(WW)) dut (
    .sys_clk(sys_clk), .rst(rst), .sclk(sclk), .mosi(mosi), .csb(csb),
    .data_out(data_out), .power_state_out(power_state_out),
    .valid(valid), .frame_err(frame_err), .busy(busy)
`ifdef SPI_SUB_RX_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int nchk = 0, nerr = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Frame-level model: events are scheduled four clocks after the csb edge is driven
  int            fall_cyc = -100, rise_cyc = -100, ev_cyc = -100;
  int            ev_kind = 0;   // 0 none, 1 good frame, 2 bad frame
  bit            skip = 1'b0;
  logic [WW-1:0] ev_data = '0, m_data = '0;
  logic [1:0]    ev_ps = 2'b00, m_ps = 2'b00;
  logic          exp_busy = 1'b0;
  logic [WW+1:0] vlog[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (rst) begin
      m_data = '0; m_ps = 2'b00; exp_busy = 1'b0; ev_kind = 0;
    end else begin
      if (cyc == fall_cyc + 4) exp_busy = 1'b1;
      if (cyc == rise_cyc + 4) exp_busy = 1'b0;
      if (cyc == ev_cyc && ev_kind == 1) begin m_data = ev_data; m_ps = ev_ps; end
    end
    chk("valid", valid, (!rst && cyc == ev_cyc && ev_kind == 1));
    chk("frame_err", frame_err, (!rst && cyc == ev_cyc && ev_kind == 2));
    chk("data_out", data_out, m_data);
    chk("power_state_out", power_state_out, m_ps);
    chk("busy", busy, exp_busy);
    if (valid) vlog.push_back({power_state_out, data_out});
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge sys_clk);
    #2;
  endtask

  // bits[n-1] is sent first; gap >= 2 is the csb-high time before this task returns
  task automatic send_frame(input logic [63:0] bits, input int n, input int lead,
                            input int ph, input int gap, input int rst_at, input bit tail_fall);
    if (n > 0) mosi = bits[n-1];
    wait_cyc(1);
    csb = 1'b0;
    fall_cyc = cyc;
    if (n == 0) wait_cyc(3);
    for (int i = 0; i < n; i++) begin
      if (i > 0 || lead > 0) begin
        mosi = bits[n-1-i];
        wait_cyc((i == 0) ? lead : ph);
      end
      sclk = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1; skip = 1'b1;
        wait_cyc(1);
        chk("rst_data_out", data_out, 0);
        chk("rst_power_state", power_state_out, 0);
        chk("rst_busy", busy, 0);
        wait_cyc(2);
        rst = 1'b0;
      end
      wait_cyc(ph);
      sclk = 1'b1;
    end
    wait_cyc(ph);
    if (n > WW + 3) chk("cnt_saturated", dut.cnt_q, WW + 3);
    csb = 1'b1;
    if (tail_fall) sclk = 1'b0;
    rise_cyc = cyc;
    ev_cyc   = cyc + 4;
    if (skip) ev_kind = 0;
    else if (n == WW + 2) begin
      ev_kind = 1; ev_data = bits[WW-1:0]; ev_ps = bits[WW+1:WW];
    end else ev_kind = 2;
    skip = 1'b0;
    if (tail_fall) begin wait_cyc(ph); sclk = 1'b1; end
    wait_cyc(gap - 1);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: got no finish, expected finish before 900us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] b;
    int n;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(10);

    // Good 18-bit frame, then a 17-bit frame that must not disturb the outputs
    send_frame({46'd0, 2'b01, 16'hA5C3}, 18, 2, 3, 6, -1, 1'b0);
    wait_cyc(4);
    chk("lit_A5C3_data", data_out, 16'hA5C3);
    chk("lit_A5C3_ps", power_state_out, 2'b01);
    send_frame(64'h1_5A5A, 17, 2, 2, 6, -1, 1'b0);
    wait_cyc(4);
    chk("lit_17bit_data_kept", data_out, 16'hA5C3);

    // Overlong frame saturates the counter
    send_frame({$urandom, $urandom}, 40, 1, 2, 6, -1, 1'b0);
    wait_cyc(4);
    chk("lit_40bit_data_kept", data_out, 16'hA5C3);

    // Reset during bit 9, rest of frame ignored, then a good frame
    send_frame({$urandom, $urandom}, 18, 2, 3, 6, 8, 1'b0);
    wait_cyc(4);
    chk("lit_after_rst_data", data_out, 0);
    send_frame({46'd0, 2'b10, 16'h1234}, 18, 2, 3, 6, -1, 1'b0);
    wait_cyc(4);
    chk("lit_1234_data", data_out, 16'h1234);
    chk("lit_1234_ps", power_state_out, 2'b10);

    // Back-to-back frames with the minimum csb gap
    vlog.delete();
    send_frame({46'd0, 2'b11, 16'hFFFF}, 18, 1, 2, 2, -1, 1'b0);
    send_frame({46'd0, 2'b00, 16'h0000}, 18, 1, 2, 6, -1, 1'b0);
    wait_cyc(4);
    chk("b2b_count", vlog.size(), 2);
    if (vlog.size() == 2) begin
      chk("b2b_first", vlog[0], {2'b11, 16'hFFFF});
      chk("b2b_second", vlog[1], {2'b00, 16'h0000});
    end

    // sclk fall coincident with csb fall (bit 1) and with csb rise (ignored)
    send_frame({46'd0, 2'b01, 16'h0F0F}, 18, 0, 2, 4, -1, 1'b1);
    wait_cyc(4);
    chk("lit_edge_cases_data", data_out, 16'h0F0F);

    // Zero-length frame
    send_frame(64'd0, 0, 0, 2, 4, -1, 1'b0);

    // Random frames
    repeat (40) begin
      b = {$urandom, $urandom};
      n = ($urandom_range(0, 9) < 6) ? WW + 2 : int'($urandom_range(0, 24));
      send_frame(b, n, $urandom_range(0, 3), $urandom_range(2, 4),
                 $urandom_range(2, 6), -1, 1'($urandom_range(0, 1)));
    end
    wait_cyc(8);

`ifdef SPI_SUB_RX_ERR_CNT_EN
    repeat (260) send_frame(64'h1, 1, 1, 2, 2, -1, 1'b0);
    wait_cyc(8);
    chk("err_count_sat", err_count, 255);
    send_frame(64'h1, 1, 1, 2, 4, -1, 1'b0);
    wait_cyc(8);
    chk("err_count_held", err_count, 255);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/spi_sub_rx.md
SPI_SUB_RX -- requirements
Module: spi_sub_rx

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16: number of data bits per frame, excluding the 2 power-state bits.
REQ-002 SHALL have port sys_clk, input, 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port sclk, input, 1: SPI clock, idles high, asynchronous to sys_clk.
REQ-005 SHALL have port mosi, input, 1: serial data, MSB first, sampled on sclk falling edge.
REQ-006 SHALL have port csb, input, 1: active-low chip select, asynchronous to sys_clk.
REQ-007 SHALL have port data_out, output, WORD_WIDTH: last good frame's data word.
REQ-008 SHALL have port power_state_out, output, 2: last good frame's power-state bits (first two bits shifted).
REQ-009 SHALL have port valid, output, 1: one-cycle pulse when data_out/power_state_out update.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on a frame with wrong bit count.
REQ-011 SHALL have port busy, output, 1: high while state is ACTIVE.

Function
REQ-012 SHALL pass sclk, mosi, csb each through a 2-flop synchronizer, then one edge-detect register; all decisions use the synchronized values.
REQ-013 SHALL support sclk frequency up to sys_clk/4 with high and low phases each >= 2 sys_clk periods; faster sclk is unsupported.
REQ-014 SHALL implement states IDLE, ACTIVE, ARMED: ARMED = reset exit with csb low, waiting for csb high.
REQ-015 SHALL transition IDLE->ACTIVE on synchronized csb falling edge, clearing shift register and bit counter.
REQ-016 SHALL, in ACTIVE, shift synchronized mosi into shift register LSB on each detected sclk falling edge and increment the bit counter.
REQ-017 SHALL saturate the bit counter at WORD_WIDTH+3 so that overlong frames never wrap to a legal count.
REQ-018 SHALL treat an sclk falling edge detected in the same cycle as the csb falling edge as bit 1 of the new frame.
REQ-019 SHALL, on synchronized csb rising edge in ACTIVE, return to IDLE; an sclk fall in that same cycle is ignored.
REQ-020 SHALL, at that csb rise, if count == WORD_WIDTH+2, load data_out = shift[WORD_WIDTH-1:0], power_state_out = shift[WORD_WIDTH+1:WORD_WIDTH], and pulse valid.
REQ-021 SHALL, at that csb rise, if count != WORD_WIDTH+2 (including 0), pulse frame_err and leave data_out/power_state_out unchanged.
REQ-022 SHALL register valid/frame_err so they assert on the 4th sys_clk rising edge after the edge at which raw csb is first sampled high (2 sync + 1 edge + 1 output).
REQ-023 SHALL accept back-to-back frames separated by >= 2 sys_clk periods of csb high.

Reset
REQ-024 SHALL, on rst, asynchronously clear data_out, power_state_out, valid, frame_err, busy, the counter, the shift register and the synchronizers.
REQ-025 SHALL, on rst release, enter ARMED (not IDLE); ARMED->IDLE on synchronized csb high; a frame interrupted by reset produces neither valid nor frame_err.

Configuration
REQ-026 SHALL, with macro SPI_SUB_RX_ERR_CNT_EN defined, add output err_count (8 bits, reset 0), incremented on each frame_err pulse and saturating at 255.
REQ-027 SHALL, without SPI_SUB_RX_ERR_CNT_EN, have no err_count port and no counter logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover WORD_WIDTH=16, 18 bits {2'b01,16'hA5C3} -> data_out=16'hA5C3, power_state_out=2'b01, valid 1 cycle, frame_err 0.
REQ-029 SHALL cover 17-bit frame after REQ-028 -> frame_err 1 cycle, data_out stays 16'hA5C3, valid 0.
REQ-030 SHALL cover 40-bit frame -> counter saturates at 19, frame_err pulses, no valid.
REQ-031 SHALL cover rst during bit 9 with csb held low -> outputs 0, busy 0; rest of that frame ignored; next 18-bit frame {2'b10,16'h1234} -> valid, data_out=16'h1234.
REQ-032 SHALL cover two 18-bit frames 16'hFFFF, 16'h0000 with 2-cycle csb gap -> two valid pulses, data values in order.
REQ-033 SHALL cover, with SPI_SUB_RX_ERR_CNT_EN, 260 short frames -> err_count=255, held.
